bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_timer_pkg.sv | 25 ++
 rtl/bcd_digit_down.sv | 45 ++++
 rtl/bcd_countdown_timer.sv | 122 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_e      : controller states (IDLE, RUN, PAUSE, DONE)
//   BCD_MAX      : largest legal BCD digit value (9)
//   presc_width  : bits needed for a prescaler counting 0..tick_div-1
//   bcd_clamp    : limits a loaded nibble to a legal BCD digit
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int presc_width(input int tick_div);
        return (tick_div <= 2) ? 1 : $clog2(tick_div);
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down with borrow.
//   clk, clr_n : clock and asynchronous active-low reset
//   load       : capture load_val (clamped to 9)
//   load_val   : digit to load
//   dec_en     : decrement this cycle (0 wraps to 9 with borrow)
//   digit      : registered digit value
//   borrow     : dec_en while the digit is 0 (enables the next digit)
//   zero       : digit is currently 0
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    output logic [3:0] digit,
    output logic       borrow,
    output logic       zero
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    assign zero   = (digit_q == 4'd0);
    assign borrow = dec_en && zero;
    assign digit  = digit_q;

    always_comb begin
        // NOTE: default assignment first so every path drives digit_d (no latch).
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_val);
        end else if (dec_en) begin
            digit_d = zero ? BCD_MAX : digit_q - 4'd1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments and a full async reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) digit_q <= 4'd0;
        else        digit_q <= digit_d;
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with load / start / pause controls.
//   TICK_DIV : clk cycles per count-down step (>= 2)
//   clk      : system clock, clr_n : asynchronous active-low reset
//   load     : load in_tens/in_ones (clamped to 9) and go idle
//   start    : begin from IDLE (nonzero count) or resume from PAUSE
//   pause    : hold count and prescaler while running
//   tens/ones: registered BCD digits
//   running  : registered, high while in RUN
//   done     : one-cycle pulse when the count reaches 00
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] in_tens,
    input  logic [3:0] in_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done
);

    localparam int PW = presc_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e        state_q,   state_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          running_q, running_d;
    logic          done_q,    done_d;

    logic tick;
    logic step_en;
    logic last_step;
    logic ones_borrow, ones_zero, tens_zero;
    logic tens_borrow_unused;

    // Tick is a clock enable; load and pause both pre-empt it in the same cycle.
    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign step_en   = tick && !load && !pause;
    assign last_step = step_en && tens_zero && (ones == 4'd1);

    bcd_digit_down u_ones (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (load),
        .load_val (in_ones),
        .dec_en   (step_en),
        .digit    (ones),
        .borrow   (ones_borrow),
        .zero     (ones_zero)
    );

    // Tens never borrows: the controller leaves RUN as the count reaches 00.
    bcd_digit_down u_tens (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (load),
        .load_val (in_tens),
        .dec_en   (ones_borrow),
        .digit    (tens),
        .borrow   (tens_borrow_unused),
        .zero     (tens_zero)
    );

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (pause && state_q == ST_RUN) begin
            state_d = ST_PAUSE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !(tens_zero && ones_zero)) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps the held prescaler phase.
                    if (start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (last_step) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_DIV = 4:
// a table of directed cycles, hand-written corner sequences, then random
// stimulus compared against a seconds-level reference model.
module tb_bcd_countdown_timer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       load, start, pause;
    logic [3:0] in_tens, in_ones;
    logic [3:0] tens, ones;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    bcd_countdown_timer #(.TICK_DIV(DIV)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .in_tens (in_tens),
        .in_ones (in_ones),
        .tens    (tens),
        .ones    (ones),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: count as an integer 0..99 plus a mode and cycle phase.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
    mode_t m_mode;
    int    m_count;
    int    m_phase;
    bit    m_done;

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_phase = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input bit l, input bit s, input bit p, input int t, input int o);
        m_done = 0;
        if (l) begin
            m_count = clamp9(t) * 10 + clamp9(o);
            m_mode  = M_IDLE;
            m_phase = 0;
        end else if (p && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
        end else if (s && m_mode == M_IDLE && m_count != 0) begin
            m_mode  = M_RUN;
            m_phase = 0;
        end else if (s && m_mode == M_PAUSE) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_mode = M_DONE;
                    m_done = 1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input int et, input int eo, input bit er, input bit ed);
        check({name, ".tens"},    32'(tens),    32'(et));
        check({name, ".ones"},    32'(ones),    32'(eo));
        check({name, ".running"}, 32'(running), 32'(er));
        check({name, ".done"},    32'(done),    32'(ed));
    endtask

    task automatic check_model(input string name);
        expect_out(name, m_count / 10, m_count % 10, m_mode == M_RUN, m_done);
    endtask

    // One clock: drive at the falling edge, clock, then sample at the next falling edge.
    task automatic cycle(input bit l, input bit s, input bit p, input logic [3:0] t, input logic [3:0] o);
        load = l; start = s; pause = p; in_tens = t; in_ones = o;
        @(posedge clk);
        model_step(l, s, p, int'(t), int'(o));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'd0, 4'd0);
    endtask

    typedef struct {
        bit         l, s, p;
        logic [3:0] it, io;
        int         et, eo;
        bit         er, ed;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit l, input bit s, input bit p, input logic [3:0] it, input logic [3:0] io,
                       input int et, input int eo, input bit er, input bit ed);
        vec_t v;
        v.l = l; v.s = s; v.p = p; v.it = it; v.io = io;
        v.et = et; v.eo = eo; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        clr_n = 1'b0; load = 0; start = 0; pause = 0; in_tens = 0; in_ones = 0;
        model_reset();

        // Load 12 and count: 12, 11, 10, 09 at four-cycle intervals.
        add(1, 0, 0, 4'h1, 4'h2, 1, 2, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 1, 2, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'h0, 4'h0, 1, 2, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 4'h0, 4'h0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 4'h0, 4'h0, 1, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h0, 0, 9, 1, 0);
        // Start with 00 is ignored.
        add(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        // 02 -> 01 -> 00 with a single-cycle done; start in DONE ignored.
        add(1, 0, 0, 4'h0, 4'h2, 0, 2, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 0, 2, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'h0, 4'h0, 0, 2, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 0);
        add(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        // Clamp F/A to 99; pause+start together in RUN pauses.
        add(1, 0, 0, 4'hF, 4'hA, 9, 9, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 9, 9, 1, 0);
        add(0, 1, 1, 4'h0, 4'h0, 9, 9, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 9, 9, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 9, 9, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'h0, 4'h0, 9, 9, 1, 0);
        add(0, 0, 0, 4'h0, 4'h0, 9, 8, 1, 0);

        #3;
        expect_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].l, vecs[i].s, vecs[i].p, vecs[i].it, vecs[i].io);
            expect_out($sformatf("vec%0d", i), vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ed);
        end

        // Pause after two cycles from 05, hold for 10, resume: step 2 cycles later.
        cycle(1, 0, 0, 4'h0, 4'h5);
        cycle(0, 1, 0, 4'h0, 4'h0);
        idle(2);
        cycle(0, 0, 1, 4'h0, 4'h0);
        expect_out("pause_enter", 0, 5, 0, 0);
        for (int i = 0; i < 9; i++) begin
            idle(1);
            expect_out($sformatf("pause_hold%0d", i), 0, 5, 0, 0);
        end
        cycle(0, 1, 0, 4'h0, 4'h0);
        expect_out("resume", 0, 5, 1, 0);
        idle(1);
        expect_out("resume_p1", 0, 5, 1, 0);
        idle(1);
        expect_out("resume_step", 0, 4, 1, 0);

        // Pause on the final tick: tick discarded, then resume finishes at once.
        cycle(1, 0, 0, 4'h0, 4'h1);
        cycle(0, 1, 0, 4'h0, 4'h0);
        idle(3);
        cycle(0, 0, 1, 4'h0, 4'h0);
        expect_out("pause_final", 0, 1, 0, 0);
        cycle(0, 1, 0, 4'h0, 4'h0);
        expect_out("pause_final_resume", 0, 1, 1, 0);
        idle(1);
        expect_out("pause_final_done", 0, 0, 0, 1);

        // Load on the final tick: no done, loaded value shown.
        cycle(1, 0, 0, 4'h0, 4'h1);
        cycle(0, 1, 0, 4'h0, 4'h0);
        idle(3);
        cycle(1, 0, 0, 4'h3, 4'h4);
        expect_out("load_final", 3, 4, 0, 0);
        idle(1);
        expect_out("load_final_after", 3, 4, 0, 0);

        // Asynchronous reset mid-RUN, between clock edges.
        cycle(1, 0, 0, 4'h4, 4'h5);
        cycle(0, 1, 0, 4'h0, 4'h0);
        idle(2);
        #2 clr_n = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            idle(1);
            expect_out($sformatf("post_rst%0d", i), 0, 0, 0, 0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
